// File: rtl/tpu_job_sequencer.sv
// Matrix-job sequencer for the mini-TPU: fetch A/B, LOAD, RUN, STORE results into a readable buffer.
// Optional macro TPU_SEQ_CHECKSUM_EN enables a running modulo-2^DW sum of buffered results.
module tpu_job_sequencer #(
  parameter int N          = 4,
  parameter int DW         = 8,
  parameter int RUN_CYCLES = 10,
  parameter int RESULT_LAT = 1,
  localparam int AW        = (N > 2) ? $clog2(N) : 1,
  localparam int INSTR_W   = 3 + 2*AW + DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               op_rd_en,
  output logic [2*AW:0]      op_rd_addr,
  input  logic [DW-1:0]      op_rd_data,
  output logic [INSTR_W-1:0] instr,
  input  logic [DW-1:0]      result,
  input  logic [2*AW-1:0]    rd_addr,
  output logic [DW-1:0]      rd_data,
  output logic [DW-1:0]      checksum
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_RUN, S_STORE, S_DRAIN} state_e;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_RUN = 2'b01, OP_LOAD = 2'b10, OP_STORE = 2'b11} op_e;

  localparam int CNT_MAX = (RUN_CYCLES > RESULT_LAT) ? RUN_CYCLES : RESULT_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(RESULT_LAT);
  localparam logic [AW-1:0] IDX_LAST   = AW'(N - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   row_q, row_d, col_q, col_d;
  logic [AW-1:0]   row_nxt, col_nxt;
  logic            idx_last;
  op_e             ins_op_q, ins_op_d;
  logic            ins_sel_q, ins_sel_d;
  logic [AW-1:0]   ins_row_q, ins_row_d, ins_col_q, ins_col_d;
  logic [DW-1:0]   ins_data;
  logic            done_q, done_d;
  logic            st_vld, wr_en;
  logic [2*AW-1:0] st_idx, wr_idx;
  logic [DW-1:0]   rd_data_q;
  logic [DW-1:0]   buf_q [2**(2*AW)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ins_op_q  <= OP_NOP;
      ins_sel_q <= 1'b0;
      ins_row_q <= '0;
      ins_col_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ins_op_q  <= ins_op_d;
      ins_sel_q <= ins_sel_d;
      ins_row_q <= ins_row_d;
      ins_col_q <= ins_col_d;
      done_q    <= done_d;
    end
  end

  // Row/col wrap by explicit compare to N-1 so non-power-of-two N stays in range.
  always_comb begin
    idx_last = (row_q == IDX_LAST) && (col_q == IDX_LAST);
    row_nxt  = row_q;
    col_nxt  = col_q + 1'b1;
    if (col_q == IDX_LAST) begin
      col_nxt = '0;
      row_nxt = (row_q == IDX_LAST) ? '0 : row_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        row_d = '0;
        col_d = '0;
        if (start) state_d = S_LOAD_A;
      end
      S_LOAD_A, S_LOAD_B, S_STORE: begin
        row_d = row_nxt;
        col_d = col_nxt;
        if (idx_last) begin
          case (state_q)
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_RUN;
            default:  state_d = S_DRAIN;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == RUN_LAST) begin
          cnt_d   = '0;
          state_d = S_STORE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Instruction fields are registered; LOAD data rides through from the operand memory
  // in the cycle it becomes valid.
  always_comb begin
    ins_op_d   = OP_NOP;
    ins_sel_d  = 1'b0;
    ins_row_d  = '0;
    ins_col_d  = '0;
    done_d     = 1'b0;
    op_rd_en   = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        op_rd_en  = 1'b1;
        ins_op_d  = OP_LOAD;
        ins_sel_d = (state_q == S_LOAD_B);
        ins_row_d = row_q;
        ins_col_d = col_q;
      end
      S_RUN: ins_op_d = OP_RUN;
      S_STORE: begin
        ins_op_d  = OP_STORE;
        ins_row_d = row_q;
        ins_col_d = col_q;
      end
      S_DRAIN: done_d = (cnt_q == DRAIN_LAST);
      default: ;
    endcase
    op_rd_addr = {ins_sel_d, row_q, col_q};
    ins_data   = (ins_op_q == OP_LOAD) ? op_rd_data : '0;
  end

  assign instr  = {ins_op_q, ins_sel_q, ins_row_q, ins_col_q, ins_data};
  assign done   = done_q;
  assign st_vld = (ins_op_q == OP_STORE);
  assign st_idx = {ins_row_q, ins_col_q};

  generate
    if (RESULT_LAT == 0) begin : g_nolat
      always_comb begin
        wr_en  = st_vld;
        wr_idx = st_idx;
      end
    end else begin : g_lat
      logic [RESULT_LAT-1:0] vld_q, vld_d;
      logic [2*AW-1:0]       idx_q [RESULT_LAT];
      logic [2*AW-1:0]       idx_d [RESULT_LAT];

      always_comb begin
        vld_d[0] = st_vld;
        idx_d[0] = st_idx;
        for (int unsigned i = 1; i < RESULT_LAT; i++) begin
          vld_d[i] = vld_q[i-1];
          idx_d[i] = idx_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
      end

      always_ff @(posedge clk) idx_q <= idx_d;

      always_comb begin
        wr_en  = vld_q[RESULT_LAT-1];
        wr_idx = idx_q[RESULT_LAT-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_idx] <= result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= buf_q[rd_addr];
  end

  assign rd_data = rd_data_q;

`ifdef TPU_SEQ_CHECKSUM_EN
  logic [DW-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == S_IDLE) && start) checksum_d = '0;
    else if (wr_en)                   checksum_d = checksum_q + result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
